// File: rtl/lc3_control_fsm_pkg.sv
// Shared definitions for the LC-3 control unit: opcodes, state encoding,
// datapath mux encodings and the bundled control-word type.
package lc3_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_JSR = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_PSE = 4'b1101;

   localparam logic [1:0] PCMUX_PC1   = 2'b00;
   localparam logic [1:0] PCMUX_BUS   = 2'b01;
   localparam logic [1:0] PCMUX_ADDER = 2'b10;

   localparam logic [1:0] ADDR2_ZERO  = 2'b00;
   localparam logic [1:0] ADDR2_OFF6  = 2'b01;
   localparam logic [1:0] ADDR2_OFF9  = 2'b10;
   localparam logic [1:0] ADDR2_OFF11 = 2'b11;

   localparam logic [1:0] ALUK_ADD   = 2'b00;
   localparam logic [1:0] ALUK_AND   = 2'b01;
   localparam logic [1:0] ALUK_NOT   = 2'b10;
   localparam logic [1:0] ALUK_PASSA = 2'b11;

   typedef enum logic [4:0] {
      HALTED    = 5'd0,
      S_18      = 5'd1,
      S_33      = 5'd2,
      S_35      = 5'd3,
      S_32      = 5'd4,
      S_01      = 5'd5,
      S_05      = 5'd6,
      S_09      = 5'd7,
      S_00      = 5'd8,
      S_22      = 5'd9,
      S_12      = 5'd10,
      S_04      = 5'd11,
      S_21      = 5'd12,
      S_20      = 5'd13,
      S_06      = 5'd14,
      S_07      = 5'd15,
      S_25      = 5'd16,
      S_27      = 5'd17,
      S_23      = 5'd18,
      S_16      = 5'd19,
      S_13      = 5'd20,
      S_13B     = 5'd21,
      PAUSE_IR1 = 5'd22,
      PAUSE_IR2 = 5'd23
   } lc3_state_t;

   typedef struct packed {
      logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
      logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic [1:0] pcmux, addr2mux, aluk;
      logic       drmux, sr1mux, sr2mux, addr1mux;
      logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
      logic       illegal_op;
   } ctrl_t;

   // Idle control word: nothing loads or drives, SRAM selected but neither read nor written.
   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c        = '0;
      c.mem_oe = 1'b1;
      c.mem_we = 1'b1;
      return c;
   endfunction

   function automatic logic op_legal(input logic [3:0] op);
      return op inside {OP_BR, OP_ADD, OP_JSR, OP_AND, OP_LDR, OP_STR, OP_NOT, OP_JMP, OP_PSE};
   endfunction

   function automatic logic is_mem_state(input lc3_state_t s);
      return s inside {S_33, S_25, S_16};
   endfunction

endpackage

// File: rtl/lc3_control_fsm_mem_wait_timer.sv
// Length timer for SRAM access states: either a fixed cycle count loaded on
// entry, or completion signalled by the memory's ready handshake.
module mem_wait_timer #(
   parameter int MEM_WAIT     = 2,
   parameter int MEM_READY_EN = 0
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic start,
   input  logic ready,
   output logic done
);

   localparam int CW = $clog2(MEM_WAIT + 1);

   logic [CW-1:0] cnt;

   // Loaded the cycle before a memory state is entered so its first cycle sees MEM_WAIT-1.
   always_ff @(posedge Clk) begin
      if (!Reset_n)
         cnt <= '0;
      else if (start)
         cnt <= CW'(MEM_WAIT - 1);
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign done = (MEM_READY_EN != 0) ? ready : (cnt == '0);

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 control unit: Moore fetch/decode/execute sequencer driving datapath
// loads, bus gates, mux selects and active-low SRAM strobes.
module lc3_control_fsm
   import lc3_pkg::*;
#(
   parameter int MEM_WAIT     = 2,
   parameter int MEM_READY_EN = 0,
   parameter int PAUSE_IR_EN  = 0
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Run,
   input  logic       Continue,
   input  logic       Mem_Ready,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic       Mem_CE,
   output logic       Mem_UB,
   output logic       Mem_LB,
   output logic       Mem_OE,
   output logic       Mem_WE,
   output logic       Illegal_Op
);

   lc3_state_t state, state_nxt;
   logic       mem_done;
   logic       mem_start;
   ctrl_t      ctl;

   // Memory states never follow one another, so "entering" is just next-is-mem while current-is-not.
   assign mem_start = is_mem_state(state_nxt) && !is_mem_state(state);

   mem_wait_timer #(
      .MEM_WAIT     (MEM_WAIT),
      .MEM_READY_EN (MEM_READY_EN)
   ) u_timer (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .start   (mem_start),
      .ready   (Mem_Ready),
      .done    (mem_done)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_n)
         state <= HALTED;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         HALTED:    if (Run) state_nxt = S_18;
         S_18:      state_nxt = S_33;
         S_33:      if (mem_done) state_nxt = S_35;
         S_35:      state_nxt = (PAUSE_IR_EN != 0) ? PAUSE_IR1 : S_32;
         PAUSE_IR1: if (Continue) state_nxt = PAUSE_IR2;
         PAUSE_IR2: if (!Continue) state_nxt = S_18;
         S_32: begin
            unique case (Opcode)
               OP_ADD:  state_nxt = S_01;
               OP_AND:  state_nxt = S_05;
               OP_NOT:  state_nxt = S_09;
               OP_BR:   state_nxt = S_00;
               OP_JMP:  state_nxt = S_12;
               OP_JSR:  state_nxt = S_04;
               OP_LDR:  state_nxt = S_06;
               OP_STR:  state_nxt = S_07;
               OP_PSE:  state_nxt = S_13;
               default: state_nxt = S_18;
            endcase
         end
         S_01, S_05, S_09:          state_nxt = S_18;
         S_00:      state_nxt = BEN ? S_22 : S_18;
         S_22, S_12, S_21, S_20:    state_nxt = S_18;
         S_04:      state_nxt = IR_11 ? S_21 : S_20;
         S_06:      state_nxt = S_25;
         S_07:      state_nxt = S_23;
         S_25:      if (mem_done) state_nxt = S_27;
         S_27:      state_nxt = S_18;
         S_23:      state_nxt = S_16;
         S_16:      if (mem_done) state_nxt = S_18;
         S_13:      if (Continue) state_nxt = S_13B;
         S_13B:     if (!Continue) state_nxt = S_18;
         default:   state_nxt = HALTED;
      endcase
   end

   always_comb begin
      ctl = ctrl_idle();
      unique case (state)
         S_18: begin
            ctl.gate_pc = 1'b1;
            ctl.ld_mar  = 1'b1;
            ctl.pcmux   = PCMUX_PC1;
            ctl.ld_pc   = 1'b1;
         end
         // Reads capture MDR in the same cycle the access completes.
         S_33, S_25: begin
            ctl.mem_oe = 1'b0;
            ctl.ld_mdr = mem_done;
         end
         S_35: begin
            ctl.gate_mdr = 1'b1;
            ctl.ld_ir    = 1'b1;
         end
         S_32: begin
            ctl.ld_ben     = 1'b1;
            ctl.illegal_op = !op_legal(Opcode);
         end
         S_01, S_05, S_09: begin
            ctl.sr1mux   = 1'b0;
            ctl.sr2mux   = IR_5;
            ctl.aluk     = (state == S_01) ? ALUK_ADD :
                           (state == S_05) ? ALUK_AND : ALUK_NOT;
            ctl.gate_alu = 1'b1;
            ctl.ld_reg   = 1'b1;
            ctl.ld_cc    = 1'b1;
         end
         S_22: begin
            ctl.addr1mux = 1'b0;
            ctl.addr2mux = ADDR2_OFF9;
            ctl.pcmux    = PCMUX_ADDER;
            ctl.ld_pc    = 1'b1;
         end
         S_12, S_20: begin
            ctl.sr1mux   = 1'b0;
            ctl.addr1mux = 1'b1;
            ctl.addr2mux = ADDR2_ZERO;
            ctl.pcmux    = PCMUX_ADDER;
            ctl.ld_pc    = 1'b1;
         end
         S_04: begin
            ctl.gate_pc = 1'b1;
            ctl.drmux   = 1'b1;
            ctl.ld_reg  = 1'b1;
         end
         S_21: begin
            ctl.addr1mux = 1'b0;
            ctl.addr2mux = ADDR2_OFF11;
            ctl.pcmux    = PCMUX_ADDER;
            ctl.ld_pc    = 1'b1;
         end
         S_06, S_07: begin
            ctl.sr1mux      = 1'b0;
            ctl.addr1mux    = 1'b1;
            ctl.addr2mux    = ADDR2_OFF6;
            ctl.gate_marmux = 1'b1;
            ctl.ld_mar      = 1'b1;
         end
         S_27: begin
            ctl.gate_mdr = 1'b1;
            ctl.drmux    = 1'b0;
            ctl.ld_reg   = 1'b1;
            ctl.ld_cc    = 1'b1;
         end
         // Store data routed from SR (IR[11:9]) through the ALU pass-through into MDR.
         S_23: begin
            ctl.sr1mux   = 1'b1;
            ctl.aluk     = ALUK_PASSA;
            ctl.gate_alu = 1'b1;
            ctl.ld_mdr   = 1'b1;
         end
         S_16:    ctl.mem_we = 1'b0;
         S_13:    ctl.ld_led = 1'b1;
         default: ;
      endcase
   end

   assign LD_MAR     = ctl.ld_mar;
   assign LD_MDR     = ctl.ld_mdr;
   assign LD_IR      = ctl.ld_ir;
   assign LD_BEN     = ctl.ld_ben;
   assign LD_CC      = ctl.ld_cc;
   assign LD_REG     = ctl.ld_reg;
   assign LD_PC      = ctl.ld_pc;
   assign LD_LED     = ctl.ld_led;
   assign GatePC     = ctl.gate_pc;
   assign GateMDR    = ctl.gate_mdr;
   assign GateALU    = ctl.gate_alu;
   assign GateMARMUX = ctl.gate_marmux;
   assign PCMUX      = ctl.pcmux;
   assign ADDR2MUX   = ctl.addr2mux;
   assign ALUK       = ctl.aluk;
   assign DRMUX      = ctl.drmux;
   assign SR1MUX     = ctl.sr1mux;
   assign SR2MUX     = ctl.sr2mux;
   assign ADDR1MUX   = ctl.addr1mux;
   assign Mem_CE     = ctl.mem_ce;
   assign Mem_UB     = ctl.mem_ub;
   assign Mem_LB     = ctl.mem_lb;
   assign Mem_OE     = ctl.mem_oe;
   assign Mem_WE     = ctl.mem_we;
   assign Illegal_Op = ctl.illegal_op;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: three configurations driven instruction by
// instruction, each instruction expanded into its expected per-cycle control trace.
module tb_lc3_control_fsm;

   logic       Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [2:0] rst_n = '0;
   logic       Run = 1'b0, Continue = 1'b0, Mem_Ready = 1'b0;
   logic       IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
   logic [3:0] Opcode = '0;

   typedef struct packed {
      logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
      logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic [1:0] pcmux, addr2mux, aluk;
      logic       drmux, sr1mux, sr2mux, addr1mux;
      logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
      logic       illegal_op;
   } ctl_t;

   ctl_t act [3];

   // dut0: MEM_WAIT=3 counter; dut1: Mem_Ready handshake; dut2: MEM_WAIT=1 with IR pause
   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
      logic gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic [1:0] pcmux, addr2mux, aluk;
      logic drmux, sr1mux, sr2mux, addr1mux;
      logic mem_ce, mem_ub, mem_lb, mem_oe, mem_we, illegal_op;

      lc3_control_fsm #(
         .MEM_WAIT     (g == 0 ? 3 : (g == 1 ? 2 : 1)),
         .MEM_READY_EN (g == 1 ? 1 : 0),
         .PAUSE_IR_EN  (g == 2 ? 1 : 0)
      ) u_dut (
         .Clk(Clk), .Reset_n(rst_n[g]), .Run(Run), .Continue(Continue),
         .Mem_Ready(Mem_Ready), .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
         .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
         .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
         .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
         .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
         .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux), .ADDR1MUX(addr1mux),
         .Mem_CE(mem_ce), .Mem_UB(mem_ub), .Mem_LB(mem_lb), .Mem_OE(mem_oe), .Mem_WE(mem_we),
         .Illegal_Op(illegal_op)
      );

      assign act[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                       gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, addr2mux, aluk,
                       drmux, sr1mux, sr2mux, addr1mux,
                       mem_ce, mem_ub, mem_lb, mem_oe, mem_we, illegal_op};
   end

   int   sel = 0;
   ctl_t exp_c;
   bit   exp_on = 1'b0;
   int   pin = 0;
   bit   noise = 1'b0;
   int   checks = 0, failures = 0, cyc_n = 0;

   function automatic int cfg_mw(input int s);
      return (s == 0) ? 3 : ((s == 1) ? 2 : 1);
   endfunction
   function automatic bit cfg_rdy(input int s);
      return s == 1;
   endfunction
   function automatic bit cfg_pause(input int s);
      return s == 2;
   endfunction

   function automatic ctl_t idle();
      ctl_t c;
      c = '0;
      c.mem_oe = 1'b1;
      c.mem_we = 1'b1;
      return c;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] w);
      checks++;
      if (a !== w) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc_n, a, w);
      end
   endtask

   // Compare process: full control word every cycle, plus pinned literal checks.
   always @(negedge Clk) begin
      if (exp_on) begin
         checks++;
         if (act[sel] !== exp_c) begin
            failures++;
            $display("FAIL trace cyc=%0d dut=%0d got=%h want=%h", cyc_n, sel, act[sel], exp_c);
         end
         case (pin)
            1: begin
               chk("rst_oe", 32'(act[sel].mem_oe), 1);
               chk("rst_we", 32'(act[sel].mem_we), 1);
               chk("rst_ld", 32'({act[sel].ld_mar, act[sel].ld_mdr, act[sel].ld_ir, act[sel].ld_ben,
                                  act[sel].ld_cc, act[sel].ld_reg, act[sel].ld_pc, act[sel].ld_led}), 0);
            end
            2: begin
               chk("add_sr2mux", 32'(act[sel].sr2mux), 1);
               chk("add_aluk", 32'(act[sel].aluk), 0);
               chk("add_gatealu", 32'(act[sel].gate_alu), 1);
               chk("add_ldreg_ldcc", 32'({act[sel].ld_reg, act[sel].ld_cc}), 3);
            end
            3: chk("illegal_op", 32'(act[sel].illegal_op), 1);
            4: chk("br_taken_pcmux", 32'({act[sel].pcmux, act[sel].ld_pc}), 32'b101);
            5: chk("str_we_oe", 32'({act[sel].mem_we, act[sel].mem_oe}), 32'b01);
            6: chk("pse_ldled", 32'(act[sel].ld_led), 1);
            default: ;
         endcase
      end
   end

   // One clock of the model: e is what the outputs must be during this cycle.
   task automatic cyc(input ctl_t e, input int p = 0, input int mr = -1);
      if (noise) begin
         Run      = 1'($urandom);
         Continue = 1'($urandom);
      end
      Mem_Ready = (mr < 0) ? 1'($urandom) : 1'(mr);
      exp_c  = e;
      pin    = p;
      exp_on = 1'b1;
      @(posedge Clk);
      #1;
      cyc_n++;
   endtask

   task automatic mem(input bit wr, input int d, input int p);
      ctl_t e;
      int   n;
      n = cfg_rdy(sel) ? d + 1 : cfg_mw(sel);
      for (int i = 0; i < n; i++) begin
         e = idle();
         if (wr) e.mem_we = 1'b0;
         else    e.mem_oe = 1'b0;
         if (!wr && i == n - 1) e.ld_mdr = 1'b1;
         cyc(e, p, cfg_rdy(sel) ? int'(i == n - 1) : -1);
      end
   endtask

   task automatic fetch(input int d, output bit paused);
      ctl_t e;
      e = idle(); e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1;
      cyc(e);
      mem(1'b0, d, 0);
      e = idle(); e.gate_mdr = 1; e.ld_ir = 1;
      cyc(e);
      paused = cfg_pause(sel);
      if (paused) begin
         noise = 0; Continue = 0;
         repeat ($urandom_range(3)) cyc(idle());
         Continue = 1; cyc(idle());
         repeat ($urandom_range(3)) cyc(idle());
         Continue = 0; cyc(idle());
         noise = 1;
      end
   endtask

   task automatic instr(input logic [3:0] op, input bit i5, input bit i11, input bit b,
                        input int d, input int p = 0);
      ctl_t e;
      bit   paused;
      bit   legal;
      Opcode = op; IR_5 = i5; IR_11 = i11; BEN = b;
      fetch($urandom_range(4), paused);
      if (paused) return;
      legal = op inside {4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110,
                         4'b0111, 4'b1001, 4'b1100, 4'b1101};
      e = idle(); e.ld_ben = 1; e.illegal_op = !legal;
      cyc(e, legal ? 0 : p);
      case (op)
         4'b0001, 4'b0101, 4'b1001: begin
            e = idle(); e.sr2mux = i5; e.gate_alu = 1; e.ld_reg = 1; e.ld_cc = 1;
            e.aluk = (op == 4'b0001) ? 2'd0 : ((op == 4'b0101) ? 2'd1 : 2'd2);
            cyc(e, p);
         end
         4'b0000: begin
            cyc(idle());
            if (b) begin
               e = idle(); e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1;
               cyc(e, p);
            end
         end
         4'b1100: begin
            e = idle(); e.addr1mux = 1; e.pcmux = 2'b10; e.ld_pc = 1;
            cyc(e);
         end
         4'b0100: begin
            e = idle(); e.gate_pc = 1; e.drmux = 1; e.ld_reg = 1;
            cyc(e);
            e = idle(); e.pcmux = 2'b10; e.ld_pc = 1;
            if (i11) e.addr2mux = 2'b11;
            else     e.addr1mux = 1;
            cyc(e);
         end
         4'b0110, 4'b0111: begin
            e = idle(); e.addr1mux = 1; e.addr2mux = 2'b01; e.gate_marmux = 1; e.ld_mar = 1;
            cyc(e);
            if (op == 4'b0110) begin
               mem(1'b0, d, 0);
               e = idle(); e.gate_mdr = 1; e.ld_reg = 1; e.ld_cc = 1;
               cyc(e);
            end else begin
               e = idle(); e.sr1mux = 1; e.aluk = 2'b11; e.gate_alu = 1; e.ld_mdr = 1;
               cyc(e);
               mem(1'b1, d, p);
            end
         end
         4'b1101: begin
            noise = 0; Continue = 0;
            e = idle(); e.ld_led = 1;
            repeat ($urandom_range(3)) cyc(e, p);
            Continue = 1; cyc(e, p);
            repeat ($urandom_range(3)) cyc(idle());
            Continue = 0; cyc(idle());
            noise = 1;
         end
         default: ;
      endcase
   endtask

   task automatic start(input int s);
      exp_on = 0; noise = 0; sel = s;
      rst_n = '0; Run = 0; Continue = 0;
      repeat (2) @(posedge Clk);
      #1;
      cyc(idle(), 1);
      rst_n[s] = 1'b1;
      cyc(idle());
      cyc(idle());
      Run = 1; cyc(idle());
      Run = 0; noise = 1;
   endtask

   task automatic reset_mid_fetch();
      ctl_t e;
      e = idle(); e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1;
      cyc(e);
      e = idle(); e.mem_oe = 0;
      cyc(e);
      rst_n[sel] = 1'b0;
      cyc(e);
      rst_n[sel] = 1'b1; noise = 0; Run = 0;
      cyc(idle(), 1);
      Run = 1; cyc(idle());
      noise = 1;
   endtask

   task automatic rand_instrs(input int n);
      for (int i = 0; i < n; i++)
         instr(4'($urandom_range(15)), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(6));
   endtask

   initial begin
      // counter-timed configuration
      start(0);
      instr(4'h1, 1'b1, 1'b0, 1'b0, 0, 2);   // ADD x1261
      instr(4'h0, 1'b0, 1'b0, 1'b0, 0);
      instr(4'h0, 1'b0, 1'b0, 1'b1, 0, 4);
      instr(4'h8, 1'b0, 1'b0, 1'b0, 0, 3);
      instr(4'hD, 1'b0, 1'b0, 1'b0, 0, 6);
      instr(4'h4, 1'b0, 1'b1, 1'b0, 0);
      instr(4'h4, 1'b0, 1'b0, 1'b0, 0);
      instr(4'hC, 1'b0, 1'b0, 1'b0, 0);
      instr(4'h6, 1'b0, 1'b0, 1'b0, 0);
      instr(4'h7, 1'b0, 1'b0, 1'b0, 0, 5);
      instr(4'h5, 1'b0, 1'b0, 1'b0, 0);
      instr(4'h9, 1'b1, 1'b0, 1'b0, 0);
      reset_mid_fetch();
      rand_instrs(60);

      // ready-handshake configuration
      start(1);
      instr(4'h7, 1'b0, 1'b0, 1'b0, 5, 5);   // Mem_Ready 5 cycles after S_16 entry
      instr(4'h6, 1'b0, 1'b0, 1'b0, 0);
      instr(4'h1, 1'b0, 1'b0, 1'b0, 0);
      rand_instrs(60);

      // single-cycle access with IR pause
      start(2);
      rand_instrs(8);

      exp_on = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
